// File: rtl/power_board_link_responder.sv
// power_board_link_responder
// Power-board end of the power-management serial link. It repeatedly sends framed
// samples of the channel picked by the link master on a single wire. Each bit is
// held for BIT_CYCLES clocks, and IDLE_CYCLES low clocks separate the frames.
// Frame layout: start(1), id[2:0], kill flag, sample MSB first, odd parity, stop(0).
//
// Ports:
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   sel[2:0]          channel select from the link master (asynchronous)
//   kill_sw           kill request from the link master (asynchronous)
//   ch_data           eight samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   inject_parity_err inverts the parity bit of the frame snapshotted while high
//   data              serial line, idles low
//   busy              high while a frame is on the line
//   frame_done        one-cycle pulse on the first idle cycle after a stop bit
//   killed            sticky kill state, cleared only by reset
module power_board_link_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int BIT_CYCLES  = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              sel,
  input  logic                    kill_sw,
  input  logic [8*DATA_WIDTH-1:0] ch_data,
  input  logic                    inject_parity_err,
  output logic                    data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    killed
);

  localparam int SHIFT_BITS = DATA_WIDTH + 4;
  localparam int BIT_W      = $clog2(BIT_CYCLES) + 1;
  localparam int IDX_W      = $clog2(SHIFT_BITS) + 1;
  localparam int GAP_W      = $clog2(IDLE_CYCLES) + 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SHIFT_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [GAP_W-1:0]       gap_reg, gap_next;
  logic [SHIFT_BITS-1:0]  shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic                   stopped_reg, stopped_next;

  logic [2:0]             sel_meta_reg, sel_sync_reg;
  logic                   kill_meta_reg, kill_sync_reg;
  logic                   killed_reg;
  logic                   data_reg, busy_reg, frame_done_reg;

  logic                   data_line, busy_line, bit_end;
  logic [DATA_WIDTH-1:0]  ch_array [8];
  logic [SHIFT_BITS-1:0]  snap_word;

  // Unpack the flat channel bus so the synchronized select can index it directly.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      assign ch_array[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign snap_word = {sel_sync_reg, killed_reg, ch_array[sel_sync_reg]};
  assign bit_end   = (bit_cnt_reg == '0);

  // Two-flop synchronizers and the sticky kill latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_meta_reg  <= '0;
      sel_sync_reg  <= '0;
      kill_meta_reg <= 1'b0;
      kill_sync_reg <= 1'b0;
      killed_reg    <= 1'b0;
    end else begin
      sel_meta_reg  <= sel;
      sel_sync_reg  <= sel_meta_reg;
      kill_meta_reg <= kill_sw;
      kill_sync_reg <= kill_meta_reg;
      killed_reg    <= killed_reg | kill_sync_reg;
    end
  end

  // Next-state logic. Every bit time counts down from BIT_LAST and is reloaded.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    idx_next     = idx_reg;
    gap_next     = gap_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    stopped_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (gap_reg == GAP_W'(1)) begin
          shift_next   = snap_word;
          // Odd parity: the XNOR reduction is 1 when the payload has an even number of ones.
          parity_next  = (~^snap_word) ^ inject_parity_err;
          bit_cnt_next = BIT_LAST;
          state_next   = ST_START;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_cnt_next = BIT_LAST;
          idx_next     = IDX_LAST;
          state_next   = ST_SHIFT;
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_end) begin
          bit_cnt_next = BIT_LAST;
          shift_next   = {shift_reg[SHIFT_BITS-2:0], 1'b0};
          if (idx_reg == '0) begin
            state_next = ST_PARITY;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          bit_cnt_next = BIT_LAST;
          state_next   = ST_STOP;
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          gap_next     = GAP_INIT;
          stopped_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line value implied by the current state. It goes through one output register.
  // That register lags the FSM by a cycle, so data, busy and frame_done stay aligned.
  always_comb begin
    data_line = 1'b0;
    case (state_reg)
      ST_START:  data_line = 1'b1;
      ST_SHIFT:  data_line = shift_reg[SHIFT_BITS-1];
      ST_PARITY: data_line = parity_reg;
      default:   data_line = 1'b0;
    endcase
  end

  assign busy_line = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      idx_reg        <= '0;
      gap_reg        <= GAP_INIT;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      stopped_reg    <= 1'b0;
      data_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      idx_reg        <= idx_next;
      gap_reg        <= gap_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      stopped_reg    <= stopped_next;
      data_reg       <= data_line;
      busy_reg       <= busy_line;
      frame_done_reg <= stopped_reg;
    end
  end

  assign data       = data_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign killed     = killed_reg;

endmodule

// File: doc/power_board_link_responder.md
Name: power_board_link_responder

Overview:
Power-board end of the FPGA power-management serial link: the transmitter that the power-management receiver samples.
- Watches the channel-select lines `sel` and the `kill_sw` line driven by the FPGA-side receiver.
- Continuously serializes framed samples of the selected channel onto the single-wire `data` line.
- Used in the power-board CPLD and as the bus-functional model in receiver testbenches.

Parameters:
- DATA_WIDTH, 12, sample bits per channel (≥1).
- BIT_CYCLES, 4, clocks each serial bit is held (≥1).
- IDLE_CYCLES, 8, low clocks between frames (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  3  channel select from link master (asynchronous to clk).
- kill_sw  in  1  kill request from link master (asynchronous).
- ch_data  in  8*DATA_WIDTH  channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- inject_parity_err  in  1  verification hook; inverts the parity bit of the frame it is sampled for.
- data  out  1  serial line to the link master; idles low.
- busy  out  1  high while a frame is on the line.
- frame_done  out  1  one-cycle pulse after each stop bit.
- killed  out  1  latched kill state.

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0: data=0, busy=0, frame_done=0, killed=0, FSM=IDLE, gap counter=IDLE_CYCLES, sync flops cleared.
- Synchronization: sel and kill_sw pass through 2-flop synchronizers, giving 2 cycles of latency.
- Kill latch: killed sets on the first cycle the synchronized kill_sw is 1. It clears only on reset.
- Frame format, each bit held BIT_CYCLES clocks, in order:
  - start (1)
  - channel id [2:0], MSB first
  - kill flag
  - sample [DATA_WIDTH-1:0], MSB first
  - parity
  - stop (0)
- Frame length is DATA_WIDTH+7 bits.
- Parity is odd over {id, kill flag, sample}: the number of ones in those bits plus parity is odd. The parity bit is XOR-inverted when inject_parity_err=1 at snapshot.
- FSM states:
  - IDLE: data=0. The gap counter decrements each cycle. On the cycle it reaches 1, the block:
    - snapshots the synchronized sel, the killed flag, ch_data[sel] and inject_parity_err into the shift register;
    - computes parity;
    - goes to START.
  - START: data=1, busy=1, BIT_CYCLES cycles, then SHIFT.
  - SHIFT: shifts out DATA_WIDTH+4 bits (id, kill, sample), each for BIT_CYCLES cycles, then PARITY.
  - PARITY: one bit time, then STOP.
  - STOP: data=0, busy=1, one bit time. Then go to IDLE, reload the gap counter to IDLE_CYCLES, and pulse frame_done=1 on the first IDLE cycle. busy falls on that same cycle.
- Outputs data, busy and frame_done are registered; there are no combinational input-to-output paths.
- First frame: after reset release, the first start bit appears on data IDLE_CYCLES+1 clocks after the first clk edge with reset_n=1.
- Snapshot rule: changes to sel, ch_data, kill or inject_parity_err during a frame do not affect that frame. They apply from the next snapshot.
- Bit-timing counter width: clog2(BIT_CYCLES)+1. Bit-index counter width: clog2(DATA_WIDTH+4)+1.
- Counter wrap: all counters reload, never wrap through zero. With BIT_CYCLES=1 each state lasts exactly 1 cycle per bit.
- Reset mid-frame: data drops to 0 immediately (asynchronous). The frame is abandoned, never resumed.

Test Plan:
1. Defaults, sel=3, ch3=0xA5C, kill_sw=0, reset released → after IDLE_CYCLES+1 clocks, data shows 4-cycle bits 1,0,1,1,0,1,0,1,0,0,1,0,1,1,1,0,0,1,0. This is parity 1 (8 ones: id 2, kill 0, sample 6, even, so parity=1), then stop 0. busy high for 76 cycles; frame_done pulses once.
2. Change sel 3→6 during frame 1 SHIFT → frame 1 completes with id 011 and 0xA5C; frame 2 starts 8 IDLE cycles later with id 110 and ch6 data.
3. Pulse kill_sw high for 3 cycles mid-frame → killed=1 within 3 cycles; current frame kill bit=0; all later frames kill bit=1 until reset_n=0.
4. inject_parity_err=1 held across one snapshot, ch0=0x000, sel=0 → that frame's parity bit=0 instead of 1; the next frame (hook low) parity=1.
5. Assert reset_n=0 during bit 7 → data=0 and busy=0 in the same cycle, no frame_done; after release the first frame is a full frame starting with a start bit.
6. BIT_CYCLES=1, IDLE_CYCLES=1, DATA_WIDTH=12 → frames of 19 cycles separated by exactly 1 idle-low cycle; frame_done every 20 cycles.
